// File: rtl/flash_play_ctrl.sv
// Streams 32-bit flash words out as two 16-bit audio samples, one per accepted
// sample_tick, walking the flash address forward or backward with wrap-around.
module flash_play_ctrl #(
    parameter logic [22:0] START_ADDR = 23'h000000,
    parameter logic [22:0] END_ADDR   = 23'h07FFFF,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic        clk50M,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        play,
    input  logic        dir,
    input  logic        restart,
    output logic        read_req,
    input  logic        read_done,
    input  logic [31:0] flash_data,
    output logic [22:0] flash_addr,
    output logic [15:0] audio_out,
    output logic        sample_valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FIRST, WAIT2, SECOND} state_t;

    state_t      state;
    logic        dir_q;
    logic        restart_pend;
    logic [31:0] word_q;
    logic [7:0]  counter;
    logic [22:0] next_addr;
    logic [22:0] restart_addr;

    always_comb begin
        next_addr = flash_addr;
        if (!dir_q)
            next_addr = (flash_addr == END_ADDR) ? START_ADDR : flash_addr + 23'd1;
        else
            next_addr = (flash_addr == START_ADDR) ? END_ADDR : flash_addr - 23'd1;
    end

    assign restart_addr = dir ? END_ADDR : START_ADDR;

    // Pulse/level outputs are set on the transition into the state that owns
    // them, so they are visible during that state without extra latency.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            flash_addr   <= START_ADDR;
            read_req     <= 1'b0;
            audio_out    <= 16'h0000;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            restart_pend <= 1'b0;
            dir_q        <= 1'b0;
            word_q       <= 32'h0;
            counter      <= 8'h0;
        end else begin
            read_req     <= 1'b0;
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (restart_pend) begin
                        flash_addr   <= restart_addr;
                        restart_pend <= 1'b0;
                    end else if (sample_tick && play) begin
                        read_req <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    dir_q   <= dir;
                    counter <= 8'h0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (read_done) begin
                        word_q       <= flash_data;
                        audio_out    <= dir_q ? flash_data[31:16] : flash_data[15:0];
                        sample_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= FIRST;
                    end else if (counter == TIMEOUT) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                FIRST: state <= WAIT2;
                WAIT2: begin
                    if (restart_pend) begin
                        // Unplayed half is dropped; playback resumes from the new origin.
                        flash_addr   <= restart_addr;
                        restart_pend <= 1'b0;
                        state        <= IDLE;
                    end else if (sample_tick && play) begin
                        audio_out    <= dir_q ? word_q[15:0] : word_q[31:16];
                        sample_valid <= 1'b1;
                        flash_addr   <= next_addr;
                        state        <= SECOND;
                    end
                end
                SECOND: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (restart)
                restart_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flash_play_ctrl.sv
// Self-checking bench for flash_play_ctrl: table-driven word playback plus
// hand-written restart, pause, timeout and reset sequences; audio via scoreboard.
module tb_flash_play_ctrl;

    logic        clk50M = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        play = 1'b0;
    logic        dir = 1'b0;
    logic        restart = 1'b0;
    logic        read_req;
    logic        read_done = 1'b0;
    logic [31:0] flash_data = 32'h0;
    logic [22:0] flash_addr;
    logic [15:0] audio_out;
    logic        sample_valid;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    flash_play_ctrl dut (
        .clk50M       (clk50M),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .play         (play),
        .dir          (dir),
        .restart      (restart),
        .read_req     (read_req),
        .read_done    (read_done),
        .flash_data   (flash_data),
        .flash_addr   (flash_addr),
        .audio_out    (audio_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .err          (err)
    );

    always #10 clk50M = ~clk50M;

    typedef struct {
        logic        do_restart;
        logic        dir;
        logic [31:0] word;
        logic [15:0] first;
        logic [15:0] second;
        logic [22:0] addr_before;
        logic [22:0] addr_after;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk50M);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic pulse_done(input logic [31:0] word);
        flash_data = word;
        read_done  = 1'b1;
        step();
        read_done  = 1'b0;
    endtask

    // Scoreboard: every sample_valid must match the oldest expected sample.
    always @(negedge clk50M) begin
        if (!reset && sample_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample actual=%h required=none", audio_out);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (audio_out !== e) begin
                    errors++;
                    $display("FAIL audio_out actual=%h required=%h", audio_out, e);
                end
            end
        end
    end

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 32'hBBBBAAAA, 16'hAAAA, 16'hBBBB, 23'h000000, 23'h000001};
        vecs[1] = '{1'b0, 1'b0, 32'h12345678, 16'h5678, 16'h1234, 23'h000001, 23'h000002};
        vecs[2] = '{1'b0, 1'b1, 32'h9ABCDEF0, 16'h9ABC, 16'hDEF0, 23'h000002, 23'h000001};
        vecs[3] = '{1'b0, 1'b1, 32'hCAFEF00D, 16'hCAFE, 16'hF00D, 23'h000001, 23'h000000};
        vecs[4] = '{1'b0, 1'b1, 32'h22221111, 16'h2222, 16'h1111, 23'h000000, 23'h07FFFF};
        vecs[5] = '{1'b0, 1'b0, 32'hDEADBEEF, 16'hBEEF, 16'hDEAD, 23'h07FFFF, 23'h000000};
        vecs[6] = '{1'b1, 1'b1, 32'h0000FFFF, 16'h0000, 16'hFFFF, 23'h07FFFF, 23'h07FFFE};
        vecs[7] = '{1'b1, 1'b0, 32'hA5A55A5A, 16'h5A5A, 16'hA5A5, 23'h000000, 23'h000001};

        repeat (3) @(posedge clk50M);
        #1 reset = 1'b0;
        step();
        chk("rst_addr", flash_addr, 23'h0);
        chk("rst_audio", audio_out, 16'h0);
        chk("rst_read_req", read_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_valid", sample_valid, 1'b0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_restart) begin
                dir = vecs[i].dir;
                restart = 1'b1;
                step();
                restart = 1'b0;
                step();
                step();
            end
            dir  = vecs[i].dir;
            play = 1'b1;
            chk("addr_before", flash_addr, vecs[i].addr_before);
            pulse_tick();
            chk("read_req_latency", read_req, 1'b1);
            chk("busy_req", busy, 1'b1);
            step();
            chk("read_req_width", read_req, 1'b0);
            dir = ~vecs[i].dir;                 // must not affect the current word
            step();
            step();
            exp_q.push_back(vecs[i].first);
            pulse_done(vecs[i].word);
            chk("first_valid", sample_valid, 1'b1);
            chk("busy_done", busy, 1'b0);
            step();
            step();
            exp_q.push_back(vecs[i].second);
            pulse_tick();
            chk("second_valid", sample_valid, 1'b1);
            step();
            chk("addr_after", flash_addr, vecs[i].addr_after);
            $display("vector %0d dir=%0d word=%h addr %h -> %h", i, vecs[i].dir, vecs[i].word,
                     vecs[i].addr_before, flash_addr);
        end

        // Restart arriving in WAIT: first half still emitted, then jump to START_ADDR.
        dir = 1'b0;
        pulse_tick();
        step();
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        exp_q.push_back(16'hAAAA);
        pulse_done(32'hBBBBAAAA);
        chk("rs_first_valid", sample_valid, 1'b1);
        step();
        step();
        chk("rs_addr_loaded", flash_addr, 23'h0);
        pulse_tick();
        chk("rs_read_req", read_req, 1'b1);
        chk("rs_read_addr", flash_addr, 23'h0);
        step();
        step();
        exp_q.push_back(16'h3333);
        pulse_done(32'h44443333);
        step();
        step();
        exp_q.push_back(16'h4444);
        pulse_tick();
        step();
        chk("rs_addr_after", flash_addr, 23'h1);
        $display("restart-in-WAIT sequence addr now %h", flash_addr);

        // Pause: ticks with play=0 in IDLE start nothing.
        play = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            chk("pause_no_req", read_req, 1'b0);
            step();
            chk("pause_idle", busy, 1'b0);
        end
        // Pause in WAIT2 holds the second half until play returns.
        play = 1'b1;
        pulse_tick();
        step();
        step();
        exp_q.push_back(16'h4321);
        pulse_done(32'h87654321);
        step();
        play = 1'b0;
        pulse_tick();
        chk("pause_wait2_no_valid", sample_valid, 1'b0);
        chk("pause_wait2_addr", flash_addr, 23'h1);
        play = 1'b1;
        exp_q.push_back(16'h8765);
        pulse_tick();
        chk("resume_valid", sample_valid, 1'b1);
        step();
        chk("resume_addr", flash_addr, 23'h2);
        $display("pause sequence addr now %h", flash_addr);

        // Timeout: no read_done at all.
        pulse_tick();
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        chk("timeout_busy_cycles_ok", (n >= 256 && n <= 258), 1'b1);
        chk("timeout_err", err, 1'b1);
        chk("timeout_addr", flash_addr, 23'h2);
        step();
        chk("timeout_err_sticky", err, 1'b1);
        $display("timeout sequence busy for %0d cycles err=%0d", n, err);

        // Reset mid-read, then a stray read_done.
        pulse_tick();
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("amid_read_req", read_req, 1'b0);
        chk("amid_busy", busy, 1'b0);
        chk("amid_err", err, 1'b0);
        chk("amid_addr", flash_addr, 23'h0);
        chk("amid_audio", audio_out, 16'h0);
        step();
        reset = 1'b0;
        pulse_done(32'hFFFFFFFF);
        chk("stray_done_valid", sample_valid, 1'b0);
        chk("stray_done_busy", busy, 1'b0);
        step();
        chk("stray_done_audio", audio_out, 16'h0);
        $display("reset mid-read sequence done");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
